simon_game_ctrl: RTL and testbench
==================================

Name: simon_game_ctrl

Overview:
- Top-level game sequencer for Simon Says. It drives the seed generator, the RNG, the colour segment store and the variable-rate flash timer.
- It plays back the stored colour sequence, then walks the player through re-entering it, one compare per submit.
- It sits between the datapath (segment store, timer, input checker) and the board I/O. It owns current_round, check_round and speed.

Parameters:
- MAX_ROUNDS, 32, round count that ends the game in WIN; legal range 1..32.
- ROUNDS_PER_SPEED, 4, rounds completed per speed step; speed saturates at 3'd4 (16 Hz).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- start_btn  in  1  single-cycle pulse; starts or restarts a game
- submit  in  1  single-cycle pulse; player confirms the current selection
- pulse  in  1  timer tick from variable_timer
- result  in  1  player input matches segment[check_round]
- empty  in  1  segment[check_round] is unassigned (msb=1)
- start  out  1  RNG seed-load strobe
- rst_seedgen  out  1  seed generator clear strobe
- clr_segments  out  1  clear all stored segments to unassigned
- load_colour  out  1  shift the new RNG colour into segment[0]
- load_speed  out  1  reload the timer using speed
- speed  out  3  timer rate code, 0..4
- flash_colour  out  1  light the colour at segment[check_round]
- player_turn  out  1  player input is being accepted
- check_round  out  5  segment index under display or compare
- current_round  out  6  number of colours in the sequence, 0..32
- game_over  out  1  game ended
- win  out  1  game ended with all MAX_ROUNDS correct

Behaviour:
- All outputs are registered or decoded from registered state. On reset: state=IDLE, all strobes 0, speed=0, check_round=0, current_round=0, game_over=0, win=0. Reset takes effect from any state.
- Segment indexing: segment[0] holds the newest colour, so the oldest colour is at index current_round-1. Playback and entry both run from oldest to newest, so check_round counts down from current_round-1 to 0.
- IDLE: everything idle; the seed generator free-runs. On start_btn, go to SEED.
- SEED (1 cycle): start=1, rst_seedgen=1 and clr_segments=1 for this one cycle. current_round<=0, win<=0, game_over<=0. Next state is ADD.
- ADD (1 cycle): load_colour=1. current_round<=current_round+1. speed<=min((current_round+1)/ROUNDS_PER_SPEED, 4) using integer divide. Next state is SPEED.
- SPEED (1 cycle): load_speed=1 with the speed value already updated. check_round<=current_round-1. Next state is SHOW_ON.
- SHOW_ON: flash_colour=1. On pulse, go to SHOW_OFF.
- SHOW_OFF: flash_colour=0. On pulse:
  - if check_round==0: check_round<=current_round-1 and go to PLAYER;
  - otherwise: check_round<=check_round-1 and go to SHOW_ON.
- Playback timing: each colour is lit for one timer period, followed by a one-period gap.
- PLAYER: player_turn=1. On submit, go to CHECK. pulse is ignored in this state.
- CHECK (1 cycle): player_turn=0, then decide as follows.
  - empty=1 → LOSE. Empty has priority over result.
  - result=0 → LOSE.
  - result=1 and check_round>0 → check_round<=check_round-1, back to PLAYER.
  - result=1, check_round==0 and current_round==MAX_ROUNDS → WIN.
  - result=1, check_round==0 and current_round<MAX_ROUNDS → ADD.
- LOSE: game_over=1, win=0. WIN: game_over=1, win=1. Both hold until start_btn, which goes to SEED.
- Ignored inputs:
  - start_btn is ignored outside IDLE, LOSE and WIN; a restart mid-game requires reset.
  - submit is ignored outside PLAYER, including a submit during playback.
  - pulse is ignored outside SHOW_ON and SHOW_OFF.
- Arithmetic widths: current_round is 6-bit and never exceeds MAX_ROUNDS. check_round is 5-bit and never underflows, because the ==0 tests come first.
- Simultaneous events: start_btn and submit asserted in the same cycle are resolved by state alone (each is only honoured in its own states).
- Every strobe (start, rst_seedgen, clr_segments, load_colour, load_speed) is exactly one cycle wide.

Test Plan:
- Reset then start_btn → one-cycle start/rst_seedgen/clr_segments, then load_colour, then load_speed with speed=0. current_round=1, flash_colour rises with check_round=0.
- Round 1 with 2 pulses, then submit with result=1 → load_colour fires, current_round=2. Playback is lit check_round=1 then 0, each lit for exactly one pulse interval.
- Force result=1 for every compare with MAX_ROUNDS=8 → speed steps 0,0,0,1,1,1,1,2 on load_speed per round. Ends with win=1, game_over=1, current_round=8.
- In round 3, submit with result=0 on the second compare (check_round=1) → LOSE, game_over=1, win=0. A later start_btn → SEED, current_round=0 then 1.
- submit and start_btn during SHOW_ON, and pulse during PLAYER → no state change; check_round unchanged.
- empty=1 together with result=1 at CHECK → LOSE. Reset asserted in SHOW_OFF → all outputs 0 next cycle and state is IDLE.

Source files
------------

// File: rtl/simon_game_ctrl_if.sv
// Board/datapath handshake bundle for the Simon game sequencer.
// The controller uses the master modport. The datapath/board side uses the slave modport.
interface simon_game_ctrl_if;
  logic       start_btn;
  logic       submit;
  logic       pulse;
  logic       result;
  logic       empty;
  logic       start;
  logic       rst_seedgen;
  logic       clr_segments;
  logic       load_colour;
  logic       load_speed;
  logic [2:0] speed;
  logic       flash_colour;
  logic       player_turn;
  logic [4:0] check_round;
  logic [5:0] current_round;
  logic       game_over;
  logic       win;

  modport master (
    input  start_btn, submit, pulse, result, empty,
    output start, rst_seedgen, clr_segments, load_colour, load_speed, speed,
           flash_colour, player_turn, check_round, current_round, game_over, win
  );

  modport slave (
    output start_btn, submit, pulse, result, empty,
    input  start, rst_seedgen, clr_segments, load_colour, load_speed, speed,
           flash_colour, player_turn, check_round, current_round, game_over, win
  );
endinterface

// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer. It plays back the stored colour sequence oldest-first,
// then checks the player's entries one submit at a time.
module simon_game_ctrl #(
  parameter int unsigned MAX_ROUNDS       = 32,
  parameter int unsigned ROUNDS_PER_SPEED = 4
) (
  input logic               clk,
  input logic               reset,
  simon_game_ctrl_if.master gif
);

  localparam int unsigned ROUND_W = 6;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned SPEED_W = 3;

  localparam logic [ROUND_W-1:0] MAX_ROUND_VAL = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] RPS_VAL       = ROUND_W'(ROUNDS_PER_SPEED);
  localparam logic [ROUND_W-1:0] SPEED_SAT     = ROUND_W'(4);

  typedef enum logic [3:0] {
    S_IDLE, S_SEED, S_ADD, S_SPEED, S_SHOW_ON, S_SHOW_OFF,
    S_PLAYER, S_CHECK, S_LOSE, S_WIN
  } state_e;

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] current_round_q, current_round_d;
  logic [IDX_W-1:0]   check_round_q, check_round_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [ROUND_W-1:0] round_inc, spd_raw;

  logic start_q, start_d;
  logic rst_seedgen_q, rst_seedgen_d;
  logic clr_segments_q, clr_segments_d;
  logic load_colour_q, load_colour_d;
  logic load_speed_q, load_speed_d;
  logic flash_q, flash_d;
  logic turn_q, turn_d;
  logic game_over_q, game_over_d;
  logic win_q, win_d;

  // Next-state and datapath update. The outputs are decoded from the next state,
  // so each registered output is in step with the state it belongs to.
  always_comb begin
    state_d         = state_q;
    current_round_d = current_round_q;
    check_round_d   = check_round_q;
    speed_d         = speed_q;
    round_inc       = current_round_q + ROUND_W'(1);
    spd_raw         = round_inc / RPS_VAL;

    unique case (state_q)
      S_IDLE: if (gif.start_btn) state_d = S_SEED;
      S_SEED: begin
        current_round_d = '0;
        state_d         = S_ADD;
      end
      S_ADD: begin
        current_round_d = round_inc;
        speed_d         = (spd_raw > SPEED_SAT) ? SPEED_W'(4) : SPEED_W'(spd_raw);
        state_d         = S_SPEED;
      end
      S_SPEED: begin
        check_round_d = IDX_W'(current_round_q - ROUND_W'(1));
        state_d       = S_SHOW_ON;
      end
      S_SHOW_ON: if (gif.pulse) state_d = S_SHOW_OFF;
      S_SHOW_OFF: begin
        if (gif.pulse) begin
          if (check_round_q == '0) begin
            check_round_d = IDX_W'(current_round_q - ROUND_W'(1));
            state_d       = S_PLAYER;
          end else begin
            check_round_d = check_round_q - IDX_W'(1);
            state_d       = S_SHOW_ON;
          end
        end
      end
      S_PLAYER: if (gif.submit) state_d = S_CHECK;
      S_CHECK: begin
        if (gif.empty || !gif.result) begin
          state_d = S_LOSE;
        end else if (check_round_q != '0) begin
          check_round_d = check_round_q - IDX_W'(1);
          state_d       = S_PLAYER;
        end else if (current_round_q == MAX_ROUND_VAL) begin
          state_d = S_WIN;
        end else begin
          state_d = S_ADD;
        end
      end
      S_LOSE, S_WIN: if (gif.start_btn) state_d = S_SEED;
      default: state_d = S_IDLE;
    endcase

    start_d        = (state_d == S_SEED);
    rst_seedgen_d  = (state_d == S_SEED);
    clr_segments_d = (state_d == S_SEED);
    load_colour_d  = (state_d == S_ADD);
    load_speed_d   = (state_d == S_SPEED);
    flash_d        = (state_d == S_SHOW_ON);
    turn_d         = (state_d == S_PLAYER);
    game_over_d    = (state_d == S_LOSE) || (state_d == S_WIN);
    win_d          = (state_d == S_WIN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      current_round_q <= '0;
      check_round_q   <= '0;
      speed_q         <= '0;
      start_q         <= 1'b0;
      rst_seedgen_q   <= 1'b0;
      clr_segments_q  <= 1'b0;
      load_colour_q   <= 1'b0;
      load_speed_q    <= 1'b0;
      flash_q         <= 1'b0;
      turn_q          <= 1'b0;
      game_over_q     <= 1'b0;
      win_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      current_round_q <= current_round_d;
      check_round_q   <= check_round_d;
      speed_q         <= speed_d;
      start_q         <= start_d;
      rst_seedgen_q   <= rst_seedgen_d;
      clr_segments_q  <= clr_segments_d;
      load_colour_q   <= load_colour_d;
      load_speed_q    <= load_speed_d;
      flash_q         <= flash_d;
      turn_q          <= turn_d;
      game_over_q     <= game_over_d;
      win_q           <= win_d;
    end
  end

  assign gif.start         = start_q;
  assign gif.rst_seedgen   = rst_seedgen_q;
  assign gif.clr_segments  = clr_segments_q;
  assign gif.load_colour   = load_colour_q;
  assign gif.load_speed    = load_speed_q;
  assign gif.speed         = speed_q;
  assign gif.flash_colour  = flash_q;
  assign gif.player_turn   = turn_q;
  assign gif.check_round   = check_round_q;
  assign gif.current_round = current_round_q;
  assign gif.game_over     = game_over_q;
  assign gif.win           = win_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl. Random games are scored against a round/index model.
module tb_simon_game_ctrl;

  localparam int MAXR = 8;
  localparam int RPS  = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_round;
  int   outcome;

  simon_game_ctrl_if gif ();

  simon_game_ctrl #(.MAX_ROUNDS(MAXR), .ROUNDS_PER_SPEED(RPS)) dut (
    .clk   (clk),
    .reset (reset),
    .gif   (gif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_speed(input int r);
    int s;
    s = r / RPS;
    return (s > 4) ? 4 : s;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_strobes"}, {gif.start, gif.rst_seedgen, gif.clr_segments,
                            gif.load_colour, gif.load_speed}, 0);
    chk({tag, "_flash_turn"}, {gif.flash_colour, gif.player_turn}, 0);
    chk({tag, "_speed"}, gif.speed, 0);
    chk({tag, "_check_round"}, gif.check_round, 0);
    chk({tag, "_current_round"}, gif.current_round, 0);
    chk({tag, "_over_win"}, {gif.game_over, gif.win}, 0);
  endtask

  // Idle cycles with stray inputs. None of them may change the visible state.
  task automatic gap(input bit in_player, input logic exp_flash, input int exp_cr);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      if (in_player) gif.pulse = 1'($urandom_range(0, 1));
      else           gif.submit = 1'($urandom_range(0, 1));
      gif.start_btn = 1'($urandom_range(0, 1));
      step();
      gif.pulse = 1'b0; gif.submit = 1'b0; gif.start_btn = 1'b0;
      chk("gap_flash", gif.flash_colour, exp_flash);
      chk("gap_turn", gif.player_turn, in_player);
      chk("gap_check_round", gif.check_round, exp_cr);
    end
  endtask

  task automatic start_game();
    gif.start_btn = 1'b1;
    step();
    gif.start_btn = 1'b0;
    chk("seed_strobes", {gif.start, gif.rst_seedgen, gif.clr_segments}, 3'b111);
    chk("seed_over_win", {gif.game_over, gif.win}, 0);
    m_round = 0;
    step();
  endtask

  // Entered in ADD. Runs the add/speed cycles and the whole playback, and ends in PLAYER.
  task automatic add_round();
    chk("add_load_colour", gif.load_colour, 1);
    chk("add_load_speed", gif.load_speed, 0);
    chk("add_current_round", gif.current_round, m_round);
    m_round++;
    step();
    chk("speed_load_speed", gif.load_speed, 1);
    chk("speed_load_colour", gif.load_colour, 0);
    chk("speed_value", gif.speed, exp_speed(m_round));
    chk("speed_current_round", gif.current_round, m_round);
    step();
    for (int idx = m_round - 1; idx >= 0; idx--) begin
      chk("show_on_flash", gif.flash_colour, 1);
      chk("show_on_index", gif.check_round, idx);
      gap(1'b0, 1'b1, idx);
      gif.pulse = 1'b1; step(); gif.pulse = 1'b0;
      chk("show_off_flash", gif.flash_colour, 0);
      chk("show_off_index", gif.check_round, idx);
      chk("show_off_load_speed", gif.load_speed, 0);
      gap(1'b0, 1'b0, idx);
      gif.pulse = 1'b1; step(); gif.pulse = 1'b0;
    end
    chk("player_entry_turn", gif.player_turn, 1);
    chk("player_entry_index", gif.check_round, m_round - 1);
    chk("player_entry_flash", gif.flash_colour, 0);
  endtask

  // Outcome: 0 means the next round is being added, 1 means a loss, 2 means a win.
  task automatic play_entry(input int fail_idx, input int fail_kind, output int res);
    res = 0;
    for (int idx = m_round - 1; idx >= 0; idx--) begin
      chk("entry_turn", gif.player_turn, 1);
      chk("entry_index", gif.check_round, idx);
      gap(1'b1, 1'b0, idx);
      gif.submit = 1'b1; step(); gif.submit = 1'b0;
      chk("check_turn", gif.player_turn, 0);
      if (idx == fail_idx) begin
        case (fail_kind)
          0:       begin gif.result = 1'b0; gif.empty = 1'b0; end
          1:       begin gif.result = 1'b1; gif.empty = 1'b1; end
          default: begin gif.result = 1'b0; gif.empty = 1'b1; end
        endcase
      end else begin
        gif.result = 1'b1; gif.empty = 1'b0;
      end
      step();
      gif.result = 1'($urandom_range(0, 1));
      gif.empty  = 1'($urandom_range(0, 1));
      if (idx == fail_idx) begin
        chk("lose_over_win", {gif.game_over, gif.win}, 2'b10);
        chk("lose_turn", gif.player_turn, 0);
        res = 1;
        return;
      end
      if (idx == 0 && m_round == MAXR) begin
        chk("win_over_win", {gif.game_over, gif.win}, 2'b11);
        chk("win_current_round", gif.current_round, MAXR);
        res = 2;
        return;
      end
    end
  endtask

  task automatic play_game(input int fail_round, input int fail_idx, input int fail_kind);
    start_game();
    for (int r = 1; r <= MAXR; r++) begin
      add_round();
      play_entry((r == fail_round) ? fail_idx : -1, fail_kind, outcome);
      if (outcome != 0) break;
    end
    // Terminal states ignore submit and pulse.
    gif.submit = 1'b1; gif.pulse = 1'b1; step(); gif.submit = 1'b0; gif.pulse = 1'b0;
    chk("hold_over", gif.game_over, 1);
    chk("hold_win", gif.win, (outcome == 2) ? 1 : 0);
    chk("hold_turn", gif.player_turn, 0);
  endtask

  initial begin
    gif.start_btn = 1'b0; gif.submit = 1'b0; gif.pulse = 1'b0;
    gif.result = 1'b0; gif.empty = 1'b0;
    reset = 1'b1;
    step(); step();
    chk_idle_outputs("reset");
    reset = 1'b0;

    gif.submit = 1'b1; gif.pulse = 1'b1; step(); gif.submit = 1'b0; gif.pulse = 1'b0;
    chk_idle_outputs("idle_ignore");

    play_game(0, -1, 0);
    chk("win_final_speed", gif.speed, exp_speed(MAXR));
    chk("win_final_round", gif.current_round, MAXR);

    reset = 1'b1; step(); reset = 1'b0;
    chk_idle_outputs("reset_in_win");

    play_game(3, 1, 0);
    play_game(2, 0, 1);
    play_game(4, 2, 2);

    for (int g = 0; g < 5; g++) begin
      int fr;
      fr = $urandom_range(1, MAXR + 2);
      play_game(fr, $urandom_range(0, (fr > MAXR ? MAXR : fr) - 1), $urandom_range(0, 2));
    end

    // Reset while playback is in its dark phase.
    start_game();
    step(); step();
    chk("pre_reset_flash", gif.flash_colour, 1);
    gif.pulse = 1'b1; step(); gif.pulse = 1'b0;
    chk("pre_reset_show_off", gif.flash_colour, 0);
    reset = 1'b1; step(); reset = 1'b0;
    chk_idle_outputs("reset_in_show_off");
    gif.pulse = 1'b1; step(); gif.pulse = 1'b0;
    chk_idle_outputs("post_reset_idle");
    start_game();
    chk("restart_load_colour", gif.load_colour, 1);
    chk("restart_round", gif.current_round, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
